// File: rtl/burst_sram_ctrl.sv
// Burst SRAM controller: single-port storage array with incrementing or wrapping
// read/write bursts, first beat executed in the request cycle.
module burst_sram_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              wrap,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  state_t             state_q, state_d;
  addr_t              addr_q, addr_d;
  addr_t              mask_q, mask_d;
  cnt_t               cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               rvalid_q, rvalid_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  cnt_t   eff_len;
  addr_t  req_mask;
  addr_t  beat_addr;
  addr_t  beat_mask;
  logic   beat_en;
  logic   beat_we;
  logic   beat_last;

  always_comb begin
    if (32'(burst_len) > DEPTH) eff_len = cnt_t'(DEPTH);
    else                        eff_len = cnt_t'(burst_len);
    // Bits set in the mask advance; cleared bits are frozen from the start address.
    if (wrap && ((eff_len & (eff_len - cnt_t'(1))) == '0))
      req_mask = addr_t'(eff_len - cnt_t'(1));
    else
      req_mask = '1;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    rvalid_d   = 1'b0;
    done_d     = 1'b0;
    beat_en    = 1'b0;
    beat_we    = 1'b0;
    beat_last  = 1'b0;
    beat_addr  = addr_q;
    beat_mask  = mask_q;

    case (state_q)
      IDLE: begin
        if (cs && (eff_len != '0)) begin
          beat_en   = 1'b1;
          beat_we   = we;
          beat_addr = addr;
          beat_mask = req_mask;
          cnt_d     = eff_len - cnt_t'(1);
          beat_last = (eff_len == cnt_t'(1));
          if (!beat_last) state_d = we ? WBURST : RBURST;
        end
      end
      default: begin
        beat_en   = 1'b1;
        beat_we   = (state_q == WBURST);
        cnt_d     = cnt_q - cnt_t'(1);
        beat_last = (cnt_q == cnt_t'(1));
        if (beat_last) state_d = IDLE;
      end
    endcase

    if (beat_en) begin
      addr_d = (beat_addr & ~beat_mask) | ((beat_addr + addr_t'(1)) & beat_mask);
      mask_d = beat_mask;
      done_d = beat_last;
      if (!beat_we) begin
        data_out_d = mem[beat_addr];
        rvalid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
    end
  end

  // Contents are never reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && beat_en && beat_we) mem[beat_addr] <= data_in;
  end

  assign data_out = data_out_q;
  assign rvalid   = rvalid_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/burst_sram_ctrl.md
BURST_SRAM_CTRL -- requirements
Module: burst_sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter LEN_W, default ADDR_W+1, burst length field width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cs  input  1  chip select; a request is issued when cs=1 in IDLE.
REQ-007 we  input  1  1 = write burst, 0 = read burst; sampled with the request.
REQ-008 addr  input  ADDR_W  start address; sampled with the request.
REQ-009 burst_len  input  LEN_W  beat count; sampled with the request.
REQ-010 wrap  input  1  0 = incrementing burst, 1 = wrapping burst; sampled with the request.
REQ-011 data_in  input  DATA_W  write data; sampled every write beat.
REQ-012 data_out  output  DATA_W  registered read data.
REQ-013 rvalid  output  1  data_out holds a valid read beat this cycle.
REQ-014 busy  output  1  burst in progress; requests are ignored while busy=1.
REQ-015 done  output  1  one-cycle pulse marking completion of a burst.

Function
REQ-016 The block SHALL hold a DEPTH x DATA_W storage array with no reset of contents.
REQ-017 FSM states SHALL be IDLE, WBURST and RBURST; busy SHALL be 1 exactly when the state is not IDLE.
REQ-018 Request accepted: cs=1 in IDLE with effective length L>=1. Beat 1 SHALL execute in the request cycle at address addr.
REQ-019 burst_len=0 SHALL be a no-op: no memory access, no rvalid, no done, and the FSM stays in IDLE.
REQ-020 burst_len > DEPTH SHALL be clamped to L = DEPTH.
REQ-021 If L>1, the FSM SHALL enter WBURST or RBURST and execute beats 2..L on the following L-1 consecutive cycles, then return to IDLE.
REQ-022 While busy=1, cs, we, addr, burst_len and wrap SHALL be ignored; bursts are never aborted.
REQ-023 Write beat k SHALL store data_in, as sampled in that beat's cycle, to beat address A(k).
REQ-024 Read beat k SHALL load mem[A(k)] into data_out and assert rvalid in the next cycle. Latency is 1; L beats give L consecutive rvalid cycles.
REQ-025 Incrementing mode: A(k) = (addr + k - 1) mod DEPTH, wrapping at the end of the array.
REQ-026 Wrap mode with L = 2**n: A(k) SHALL keep the address bits above bit n-1 from addr and advance the low n bits modulo L.
REQ-027 Wrap mode with L not a power of two SHALL behave as incrementing mode.
REQ-028 Write done SHALL pulse in the cycle after the last write beat's edge. Read done SHALL coincide with the last rvalid.
REQ-029 A new request SHALL be accepted in the first cycle the FSM is back in IDLE, giving back-to-back bursts with no gap cycle.
REQ-030 data_out SHALL hold its last value when rvalid=0. rvalid SHALL be 0 in every cycle with no read beat in flight.
REQ-031 An L=1 burst SHALL leave the FSM in IDLE, with busy=0 throughout.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, busy=0, rvalid=0, done=0, data_out=0 and clear the internal beat counter and address register.
REQ-033 Reset asserted mid-burst SHALL abandon the burst. Words already written SHALL remain; no further beats SHALL occur after reset release.
REQ-034 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Incrementing write/read: write addr=4, L=3 with data 0x11, 0x22, 0x33. Read addr=4, L=3 -> rvalid for 3 cycles with data 0x11, 0x22, 0x33, and done on the third.
REQ-036 End-of-array wrap: write addr=14, L=4 (DEPTH=16) with 0xA0..0xA3 -> mem[14]=0xA0, mem[15]=0xA1, mem[0]=0xA2, mem[1]=0xA3.
REQ-037 Wrap mode: read addr=6, L=4, wrap=1 -> addresses 6, 7, 4, 5. Wrap mode with L=3 at addr=6 -> addresses 6, 7, 8.
REQ-038 Boundary lengths: burst_len=0 -> no rvalid, no done, busy=0. burst_len=20 on a 16-deep array -> exactly 16 beats.
REQ-039 Requests during busy, and back-to-back bursts: cs=1 with a new addr during a burst -> ignored. A request in the first IDLE cycle after done -> accepted with no gap.
REQ-040 Mid-burst reset: rst_n=0 on beat 3 of an L=8 write -> outputs zero immediately, beats 1-2 persist in memory, and locations of beats 4-8 are unchanged.
